// File: rtl/param_updown_counter.sv
// Loadable up/down modulo-MODULUS counter with optional saturation,
// combinational terminal count and a registered one-cycle wrap pulse.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
    localparam bit               SAT       = (SATURATE != 0);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             at_max;
    logic             at_min;

    assign at_max = (count == MAX_COUNT);
    assign at_min = (count == '0);
    assign tc     = up_dn ? at_max : at_min;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = ({1'b0, d} >= MOD_EXT) ? MAX_COUNT : d;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    count_next = count + 1'b1;
                end else if (!SAT) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_next = count - 1'b1;
                end else if (!SAT) begin
                    count_next = MAX_COUNT;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset here is synchronous and only acts on a clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised and directed bench for param_updown_counter; three instances
// (mod-10 wrap, mod-10 saturate, mod-16 wrap) share stimulus and a modulo model.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic       up_dn = 1'b0;

    logic [3:0] cnt [3];
    logic [2:0] tc_v;
    logic [2:0] wrap_v;

    int checks = 0;
    int failures = 0;

    // Reference model state, one entry per instance.
    int mod_n [3] = '{10, 10, 16};
    bit sat_m [3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt [3] = '{0, 0, 0};
    bit m_wrap[3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap10 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .up_dn(up_dn),
        .count(cnt[0]), .tc(tc_v[0]), .wrap(wrap_v[0])
    );
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat10 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .up_dn(up_dn),
        .count(cnt[1]), .tc(tc_v[1]), .wrap(wrap_v[1])
    );
    param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_wrap16 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .up_dn(up_dn),
        .count(cnt[2]), .tc(tc_v[2]), .wrap(wrap_v[2])
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit l, input bit e,
                              input bit u, input int dv);
        int m;
        m = mod_n[i];
        if (!r) begin
            m_cnt[i] = 0;  m_wrap[i] = 1'b0;
        end else if (l) begin
            m_cnt[i] = (dv >= m) ? m - 1 : dv;  m_wrap[i] = 1'b0;
        end else if (e) begin
            int edge_val;
            edge_val = u ? m - 1 : 0;
            if (m_cnt[i] == edge_val && sat_m[i]) begin
                m_wrap[i] = 1'b0;
            end else begin
                m_wrap[i] = (m_cnt[i] == edge_val);
                m_cnt[i]  = u ? (m_cnt[i] + 1) % m : (m_cnt[i] + m - 1) % m;
            end
        end else begin
            m_wrap[i] = 1'b0;
        end
    endtask

    // Drive on negedge, check tc there, step model on posedge, check registers #1 later.
    task automatic cycle(input bit r, input bit l, input bit e, input bit u, input logic [3:0] dv);
        @(negedge clk);
        reset = r;  load = l;  en = e;  up_dn = u;  d = dv;
        #1;
        for (int i = 0; i < 3; i++) begin
            int tc_exp;
            tc_exp = u ? int'(m_cnt[i] == mod_n[i] - 1) : int'(m_cnt[i] == 0);
            check($sformatf("tc[%0d]", i), int'(tc_v[i]), tc_exp);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, r, l, e, u, int'(dv));
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("count[%0d]", i), int'(cnt[i]), m_cnt[i]);
            check($sformatf("wrap[%0d]", i), int'(wrap_v[i]), int'(m_wrap[i]));
        end
    endtask

    initial begin
        int seq_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int seq_dn [4]  = '{2, 1, 0, 9};

        // 1: reset held with load and en active
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        check("t1_count", int'(cnt[0]), 0);
        check("t1_wrap", int'(wrap_v[0]), 0);
        check("t1_tc_up", int'(tc_v[0]), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
        check("t1_tc_dn", int'(tc_v[0]), 1);

        // 2: count up through the 9 -> 0 wrap
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
            check("t2_count", int'(cnt[0]), seq_up[i]);
            check("t2_wrap", int'(wrap_v[0]), (i == 9) ? 1 : 0);
            check("t2_sat", int'(cnt[1]), (i < 8) ? i + 1 : 9);
        end

        // 3: load beats en, then count down through 0 -> 9
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        check("t3_load", int'(cnt[0]), 3);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            check("t3_count", int'(cnt[0]), seq_dn[i]);
            check("t3_wrap", int'(wrap_v[0]), (i == 3) ? 1 : 0);
        end

        // 4: clamped load, saturation at both ends
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
        check("t4_clamp10", int'(cnt[0]), 9);
        check("t4_noclamp16", int'(cnt[2]), 15);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
            check("t4_sat_hi", int'(cnt[1]), 9);
            check("t4_sat_hi_wrap", int'(wrap_v[1]), 0);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            check("t4_sat_lo", int'(cnt[1]), 0);
            check("t4_sat_lo_wrap", int'(wrap_v[1]), 0);
        end

        // 5: reset mid-count, then resume
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        check("t5_at6", int'(cnt[0]), 6);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        check("t5_reset", int'(cnt[0]), 0);
        check("t5_wrap", int'(wrap_v[0]), 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        check("t5_resume1", int'(cnt[0]), 1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        check("t5_resume2", int'(cnt[0]), 2);

        // 6: disabled, direction toggling only moves tc
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, i[0], 4'd0);
            check("t6_hold", int'(cnt[0]), 2);
        end

        // Random soak against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 24) != 0, $urandom_range(0, 9) == 0,
                  1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
